// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing from the board clock using a 1-in-DIV pixel strobe.
// Ports: CLK/RST (sync, active-high); PIX_STB pixel-slot pulse; HSYNC/VSYNC sync pins
// (level SYNC_POL when asserted); ACTIVE visible area; X/Y pixel counts;
// LINE_END last-pixel strobe; FRAME_START strobe of pixel (0,0).
module vga_sync_gen #(
    parameter int DIV      = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       PIX_STB,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       ACTIVE,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       LINE_END,
    output logic       FRAME_START
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_END = PW'(DIV - 1);
    localparam logic [9:0] H_END  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_END  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] H_ACT  = 10'(H_VIS);
    localparam logic [9:0] V_ACT  = 10'(V_VIS);
    logic [PW-1:0] phase;
    logic [9:0]    h_cnt, v_cnt;
    // The strobe flop rises on the DIV-th edge after reset, so the first pixel slot
    // lands DIV cycles after release; counters step on the edge that ends a slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase   <= '0;
            PIX_STB <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            phase   <= phase == PH_END ? '0 : phase + 1'b1;
            PIX_STB <= phase == PH_END;
            if (PIX_STB) begin
                h_cnt <= h_cnt == H_END ? '0 : h_cnt + 1'b1;
                if (h_cnt == H_END)
                    v_cnt <= v_cnt == V_END ? '0 : v_cnt + 1'b1;
            end
        end
    end
    // Decodes come straight off the counter flops: no extra latency versus X/Y.
    always_comb begin
        X           = h_cnt;
        Y           = v_cnt;
        HSYNC       = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
        VSYNC       = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
        ACTIVE      = h_cnt < H_ACT && v_cnt < V_ACT;
        LINE_END    = PIX_STB && h_cnt == H_END;
        FRAME_START = PIX_STB && h_cnt == '0 && v_cnt == '0;
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: table, directed and randomized-reset checks of vga_sync_gen against an arithmetic model.
module tb_vga_sync_gen;
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 5, SVF = 1, SVS = 2, SVB = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_d = 1'b1;
    logic [25:0] o_s, o_p, o_1, o_d;
    int n = 0, nd = 0;
    int checks = 0, failures = 0;
    typedef struct {
        int n;
        logic [25:0] v;
    } vec_t;
    vec_t tbl[16];
    always #5 clk = ~clk;
    always @(posedge clk) begin
        n  <= rst ? 0 : n + 1;
        nd <= rst_d ? 0 : nd + 1;
    end
    vga_sync_gen #(.DIV(4), .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)) u_s (
        .CLK(clk), .RST(rst), .PIX_STB(o_s[25]), .HSYNC(o_s[24]), .VSYNC(o_s[23]),
        .ACTIVE(o_s[22]), .X(o_s[19:10]), .Y(o_s[9:0]), .LINE_END(o_s[21]), .FRAME_START(o_s[20]));
    vga_sync_gen #(.DIV(4), .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)) u_p (
        .CLK(clk), .RST(rst), .PIX_STB(o_p[25]), .HSYNC(o_p[24]), .VSYNC(o_p[23]),
        .ACTIVE(o_p[22]), .X(o_p[19:10]), .Y(o_p[9:0]), .LINE_END(o_p[21]), .FRAME_START(o_p[20]));
    vga_sync_gen #(.DIV(1), .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)) u_1 (
        .CLK(clk), .RST(rst), .PIX_STB(o_1[25]), .HSYNC(o_1[24]), .VSYNC(o_1[23]),
        .ACTIVE(o_1[22]), .X(o_1[19:10]), .Y(o_1[9:0]), .LINE_END(o_1[21]), .FRAME_START(o_1[20]));
    vga_sync_gen u_d (
        .CLK(clk), .RST(rst_d), .PIX_STB(o_d[25]), .HSYNC(o_d[24]), .VSYNC(o_d[23]),
        .ACTIVE(o_d[22]), .X(o_d[19:10]), .Y(o_d[9:0]), .LINE_END(o_d[21]), .FRAME_START(o_d[20]));
    function automatic logic [25:0] mk(input int x, input int y, input bit stb, input bit hs,
                                       input bit vs, input bit act, input bit le, input bit fs);
        return {stb, hs, vs, act, le, fs, 10'(x), 10'(y)};
    endfunction
    // n = clock edges since reset released; pixel index advances once per DIV edges.
    function automatic logic [25:0] ref_out(input int cnt, input int div, input bit pol,
                                            input int hv, input int hf, input int hsw, input int hb,
                                            input int vv, input int vf, input int vsw, input int vb);
        int ht, vt, pix, x, y;
        bit stb;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        pix = cnt == 0 ? 0 : (cnt - 1) / div;
        x   = pix % ht;
        y   = (pix / ht) % vt;
        stb = cnt > 0 && cnt % div == 0;
        return mk(x, y, stb,
                  (x >= hv + hf && x < hv + hf + hsw) ? pol : !pol,
                  (y >= vv + vf && y < vv + vf + vsw) ? pol : !pol,
                  x < hv && y < vv, stb && x == ht - 1, stb && x == 0 && y == 0);
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    task automatic cmp_all();
        chk("mon_div4", 32'(o_s), 32'(ref_out(n, 4, 1'b0, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)));
        chk("mon_pol1", 32'(o_p), 32'(ref_out(n, 4, 1'b1, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)));
        chk("mon_div1", 32'(o_1), 32'(ref_out(n, 1, 1'b0, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)));
        chk("mon_vga", 32'(o_d), 32'(ref_out(nd, 4, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33)));
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask
    task automatic run_to(input int target);
        for (int g = 0; g < 4000 && n < target; g++) tick();
        chk("reach_n", 32'(n), 32'(target));
    endtask
    initial begin
        int t_act, t_hf, t_hr, t_le1, t_le2, low, l1, l2;
        tbl[0]  = '{0,   mk(0, 0, 0, 1, 1, 1, 0, 0)};
        tbl[1]  = '{3,   mk(0, 0, 0, 1, 1, 1, 0, 0)};
        tbl[2]  = '{4,   mk(0, 0, 1, 1, 1, 1, 0, 1)};
        tbl[3]  = '{5,   mk(1, 0, 0, 1, 1, 1, 0, 0)};
        tbl[4]  = '{8,   mk(1, 0, 1, 1, 1, 1, 0, 0)};
        tbl[5]  = '{33,  mk(8, 0, 0, 1, 1, 0, 0, 0)};
        tbl[6]  = '{41,  mk(10, 0, 0, 0, 1, 0, 0, 0)};
        tbl[7]  = '{53,  mk(13, 0, 0, 1, 1, 0, 0, 0)};
        tbl[8]  = '{60,  mk(14, 0, 1, 1, 1, 0, 1, 0)};
        tbl[9]  = '{61,  mk(0, 1, 0, 1, 1, 1, 0, 0)};
        tbl[10] = '{301, mk(0, 5, 0, 1, 1, 0, 0, 0)};
        tbl[11] = '{361, mk(0, 6, 0, 1, 0, 0, 0, 0)};
        tbl[12] = '{480, mk(14, 7, 1, 1, 0, 0, 1, 0)};
        tbl[13] = '{481, mk(0, 8, 0, 1, 1, 0, 0, 0)};
        tbl[14] = '{540, mk(14, 8, 1, 1, 1, 0, 1, 0)};
        tbl[15] = '{544, mk(0, 0, 1, 1, 1, 1, 0, 1)};
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            run_to(tbl[i].n);
            chk($sformatf("tbl_n%0d", tbl[i].n), 32'(o_s), 32'(tbl[i].v));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_to(406);
        chk("mid_pre_div4", 32'(o_s), 32'(mk(11, 6, 0, 0, 0, 0, 0, 0)));
        chk("mid_pre_pol1", 32'(o_p[24:23]), 32'(2'b11));
        rst = 1'b1;
        tick();
        chk("mid_rst_div4", 32'(o_s), 32'(mk(0, 0, 0, 1, 1, 1, 0, 0)));
        chk("mid_rst_pol1", 32'(o_p), 32'(mk(0, 0, 0, 0, 0, 1, 0, 0)));
        rst = 1'b0;
        repeat (3) tick();
        chk("restart_n3", 32'(o_s), 32'(mk(0, 0, 0, 1, 1, 1, 0, 0)));
        tick();
        chk("restart_n4", 32'(o_s), 32'(mk(0, 0, 1, 1, 1, 1, 0, 1)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        low = 0;
        l1 = -1;
        l2 = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!o_1[25]) low++;
            if (o_1[21]) begin
                if (l1 < 0) l1 = n;
                else if (l2 < 0) l2 = n;
            end
        end
        chk("div1_stb_low", 32'(low), 32'(0));
        chk("div1_le_first", 32'(l1), 32'(15));
        chk("div1_line_period", 32'(l2 - l1), 32'(15));
        rst_d = 1'b0;
        t_act = -1;
        t_hf = -1;
        t_hr = -1;
        t_le1 = -1;
        t_le2 = -1;
        for (int i = 0; i < 7000 && t_le2 < 0; i++) begin
            tick();
            if (t_act < 0 && !o_d[22]) t_act = nd;
            if (t_hf < 0 && !o_d[24]) t_hf = nd;
            if (t_hf >= 0 && t_hr < 0 && o_d[24]) t_hr = nd;
            if (o_d[21]) begin
                if (t_le1 < 0) t_le1 = nd;
                else if (t_le2 < 0) t_le2 = nd;
            end
        end
        chk("vga_active_fall", 32'(t_act), 32'(2561));
        chk("vga_hsync_fall", 32'(t_hf), 32'(2625));
        chk("vga_hsync_low_clk", 32'(t_hr - t_hf), 32'(384));
        chk("vga_line_end1", 32'(t_le1), 32'(3200));
        chk("vga_line_end2", 32'(t_le2), 32'(6400));
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 99) == 0;
            tick();
        end
        rst = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
